// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin arbiter that shares one ALU mux datapath
// between two requesters, holds the ALU inputs for a fixed settle time,
// captures the result and hands it back over a valid/ready response port.
module alu_op_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op,
  input  logic [9:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op,
  input  logic [9:0]  req1_data,
  output logic        req1_ready,
  output logic [1:0]  alu_a,
  output logic [1:0]  alu_b,
  output logic [9:0]  alu_in,
  input  logic [9:0]  alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [9:0]  rsp_data,
  output logic        busy,
  output logic [15:0] done_cnt
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DONE_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              rr_ptr;
  logic [CNT_W-1:0]  settle_cnt;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              capture;
  logic              handoff;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, arbitration and the combinational ready strobes
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    handoff    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        // rr_ptr names the favoured requester when both are pending
        if (req0_valid && req1_valid) begin
          grant1 = rr_ptr;
          grant0 = ~rr_ptr;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          handoff    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_op   = req0_op;
    sel_data = req0_data;
    if (grant1) begin
      sel_op   = req1_op;
      sel_data = req1_data;
    end
  end

  // Datapath: ALU drive, settle countdown, result capture, bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_in     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      done_cnt   <= '0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (accept) begin
        alu_a      <= sel_op[3:2];
        alu_b      <= sel_op[1:0];
        alu_in     <= sel_data;
        rsp_id     <= grant1;
        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      end
      if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_valid <= 1'b1;
      end
      if (handoff) begin
        rsp_valid <= 1'b0;
        done_cnt  <= done_cnt + DONE_W'(1);
        rr_ptr    <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the scheduler.
module tb_alu_op_scheduler;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [9:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [1:0]  alu_a, alu_b;
  logic [9:0]  alu_in, alu_out;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [9:0]  rsp_data;
  logic        busy;
  logic [15:0] done_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_in(alu_in), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .done_cnt(done_cnt)
  );

  // Behavioural ALU: x = in[3:0], y = in[7:4]
  function automatic logic [9:0] alu_f(input logic [1:0] a, input logic [1:0] b, input logic [9:0] d);
    logic [3:0] x, y;
    x = d[3:0];
    y = d[7:4];
    case (a)
      2'd0: case (b)
        2'd0: return 10'(x) + 10'(y);
        2'd1: return 10'(x) - 10'(y);
        2'd2: return 10'(x) * 10'(y);
        default: return {d[9:8], y, x};
      endcase
      2'd1: case (b)
        2'd0: return {6'd0, x & y};
        2'd1: return {6'd0, x | y};
        2'd2: return {6'd0, x ^ y};
        default: return {6'd0, ~x};
      endcase
      2'd2: case (b)
        2'd0: return {9'd0, y == x};
        2'd1: return {9'd0, y > x};
        2'd2: return {9'd0, y < x};
        default: return {9'd0, y != x};
      endcase
      default: return d ^ 10'h2A5;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_in);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model
  bit          m_out;
  bit          m_id;
  logic [9:0]  m_res;
  int          m_age;
  bit          m_fav;
  logic [15:0] m_done;
  logic [1:0]  m_a, m_b;
  logic [9:0]  m_in;
  int          cyc = 0;
  int          acc_cyc = -1, vld_cyc = -1, hs_cyc = -1;
  int          hs_ids[$];
  logic [9:0]  hs_data[$];

  task automatic model_reset();
    m_out = 0; m_id = 0; m_res = '0; m_age = 0; m_fav = 0;
    m_done = '0; m_a = '0; m_b = '0; m_in = '0;
  endtask

  // One clock cycle: check outputs at negedge, advance model, move past posedge
  task automatic step();
    bit g0, g1, exp_valid;
    logic [3:0] op;
    logic [9:0] dat;
    @(negedge clk);
    if (!reset) begin
      g0 = 0; g1 = 0;
      if (!m_out) begin
        if (req0_valid && req1_valid) begin
          g1 = m_fav; g0 = !m_fav;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      exp_valid = m_out && (m_age >= 1 + SETTLE);
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("busy", 32'(busy), 32'(m_out));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_in", 32'(alu_in), 32'(m_in));
      check("done_cnt", 32'(done_cnt), 32'(m_done));
      if (exp_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_data", 32'(rsp_data), 32'(m_res));
      end
      if (rsp_valid === 1'b1 && vld_cyc < 0) vld_cyc = cyc;
      if (m_out) begin
        if (exp_valid && rsp_ready) begin
          hs_ids.push_back(int'(m_id));
          hs_data.push_back(rsp_data);
          hs_cyc = cyc;
          m_out  = 0;
          m_done = m_done + 16'd1;
          m_fav  = !m_id;
        end else begin
          m_age++;
        end
      end else if (g0 || g1) begin
        op    = g1 ? req1_op : req0_op;
        dat   = g1 ? req1_data : req0_data;
        m_out = 1; m_age = 1; m_id = g1;
        m_a = op[3:2]; m_b = op[1:0]; m_in = dat;
        m_res = alu_f(op[3:2], op[1:0], dat);
        acc_cyc = cyc;
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [9:0] snap;
    logic [9:0] tmp;
    int exp_ids[4];
    exp_ids = '{0, 1, 0, 1};

    reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = '0; req1_op = '0; req0_data = '0; req1_data = '0;
    model_reset();
    step(); step();
    reset = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);

    // Add: x=5, y=3 -> 8, latency SETTLE+1
    req0_valid = 1; req0_op = 4'h0; req0_data = 10'h035; rsp_ready = 1;
    vld_cyc = -1; hs_ids.delete(); hs_data.delete();
    step();
    req0_valid = 0;
    for (int i = 0; i < 20 && hs_ids.size() < 1; i++) step();
    check("add_hs_count", 32'(hs_ids.size()), 32'd1);
    check("add_latency", 32'(vld_cyc - acc_cyc), 32'(1 + SETTLE));
    if (hs_data.size() > 0) begin
      tmp = hs_data[0];
      check("add_lo", 32'(tmp[3:0]), 32'h8);
      check("add_b9", 32'(tmp[9]), 32'd0);
      check("add_id", 32'(hs_ids[0]), 32'd0);
    end
    step();
    check("done_one", 32'(done_cnt), 32'd1);

    // Reset mid-SETTLE aborts the operation
    req0_valid = 1; req0_op = 4'hB; req0_data = 10'h3C7; rsp_ready = 1;
    step();
    req0_valid = 0; reset = 1;
    vld_cyc = -1;
    step();
    reset = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check("abort_alu_b", 32'(alu_b), 32'd0);
    check("abort_alu_in", 32'(alu_in), 32'd0);
    check("abort_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("abort_no_valid", 32'(vld_cyc), 32'hFFFF_FFFF);

    // Both requesters pending: grants alternate starting at req0
    req0_valid = 1; req1_valid = 1; req0_op = 4'h4; req1_op = 4'h4;
    req0_data = 10'h0F6; req1_data = 10'h1A9; rsp_ready = 1;
    hs_ids.delete(); hs_data.delete();
    for (int i = 0; i < 40 && hs_ids.size() < 4; i++) step();
    req0_valid = 0; req1_valid = 0;
    check("rr_hs_count", 32'(hs_ids.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_ids.size(); i++)
      check("rr_id", 32'(hs_ids[i]), 32'(exp_ids[i]));
    step();

    // Back-pressure: response held, req1 waits until the cycle after handshake
    req0_valid = 1; req0_op = 4'h6; req0_data = 10'h2B4; rsp_ready = 0;
    step();
    req0_valid = 0; req1_valid = 1; req1_op = 4'h1; req1_data = 10'h097;
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) step();
    snap = rsp_data;
    for (int i = 0; i < 10; i++) step();
    check("bp_data_hold", 32'(rsp_data), 32'(snap));
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_req1_ready", 32'(req1_ready), 32'd0);
    rsp_ready = 1;
    step();
    step();
    req1_valid = 0;
    check("bp_next_accept", 32'(acc_cyc - hs_cyc), 32'd1);
    for (int i = 0; i < 8; i++) step();

    // Compare gt: y=5 > x=2
    req0_valid = 1; req0_op = 4'h9; req0_data = 10'h052; rsp_ready = 0;
    step();
    req0_valid = 0;
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) step();
    step();
    check("cmp_alu_a", 32'(alu_a), 32'd2);
    check("cmp_alu_b", 32'(alu_b), 32'd1);
    tmp = rsp_data;
    check("cmp_bit0", 32'(tmp[0]), 32'd1);
    rsp_ready = 1;
    step();

    // done_cnt wrap from 16'hFFFF
    rsp_ready = 0;
    step();
    force dut.done_cnt = 16'hFFFF;
    m_done = 16'hFFFF;
    step();
    release dut.done_cnt;
    step();
    req0_valid = 1; req0_op = 4'h2; req0_data = 10'h011; rsp_ready = 1;
    step();
    req0_valid = 0;
    for (int i = 0; i < 10 && busy === 1'b1; i++) step();
    check("wrap_done", 32'(done_cnt), 32'h0000);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_op    = 4'($urandom);
      req1_op    = 4'($urandom);
      req0_data  = 10'($urandom);
      req1_data  = 10'($urandom);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      step();
    end
    reset = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
